// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned PROD_W        = 2 * XLEN;
    localparam int unsigned CNT_W         = 5;
    localparam int unsigned DEF_STEP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    // Number of CALC cycles for a given number of multiplier bits per step
    function automatic int unsigned n_iter(input int unsigned step);
        return XLEN / step;
    endfunction

    localparam int unsigned N_ITER = n_iter(DEF_STEP_BITS);

endpackage

// File: rtl/muldiv_step_adder.sv
// Partial-product step: adds multiplicand x digit into the accumulator.
module muldiv_step_adder
    import muldiv_pkg::*;
#(
    parameter int unsigned STEP_BITS = DEF_STEP_BITS
) (
    input  logic [PROD_W-1:0]    acc,
    input  logic [PROD_W-1:0]    mcand,
    input  logic [STEP_BITS-1:0] digit,
    output logic [PROD_W-1:0]    sum
);

    // Shift-add each set digit bit of the multiplier slice
    always_comb begin
        sum = acc;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            if (digit[i]) begin
                sum = sum + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Clocked, interlocked MULT/MULTU sequencer with HI/LO registers.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned STEP_BITS = DEF_STEP_BITS,
    parameter int unsigned W         = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         mf_req,
    input  logic         mf_sel_hi,
    input  logic         flush,
    output logic [W-1:0] mf_data,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int unsigned NIT = n_iter(STEP_BITS);

    state_t            state;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] acc_sum;
    logic [PROD_W-1:0] prod;
    logic [W-1:0]      mplier;
    logic [W-1:0]      abs_a;
    logic [W-1:0]      abs_b;
    logic [CNT_W-1:0]  cnt;
    logic              neg;

    muldiv_step_adder #(
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .acc   (acc),
        .mcand (mcand),
        .digit (mplier[STEP_BITS-1:0]),
        .sum   (acc_sum)
    );

    // Operand magnitudes; -2^31 maps onto itself and is used unsigned
    always_comb begin
        abs_a = (is_signed && op_a[W-1]) ? -op_a : op_a;
        abs_b = (is_signed && op_b[W-1]) ? -op_b : op_b;
        prod  = neg ? -acc : acc;
    end

    // Hazard interlock and MFHI/MFLO read path
    always_comb begin
        busy    = (state != IDLE);
        stall   = busy & (start | mf_req);
        mf_data = mf_sel_hi ? hi : lo;
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        mcand  <= {{(PROD_W-W){1'b0}}, abs_a};
                        mplier <= abs_b;
                        neg    <= is_signed & (op_a[W-1] ^ op_b[W-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(NIT - 1);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_sum;
                        mcand  <= mcand << STEP_BITS;
                        mplier <= mplier >> STEP_BITS;
                        cnt    <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    if (!flush) begin
                        hi   <= prod[PROD_W-1:W];
                        lo   <= prod[W-1:0];
                        done <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl (STEP_BITS=1 main unit, STEP_BITS=2 spot check).
module tb_muldiv_seq_ctrl;

    localparam int unsigned NIT = 32;

    typedef struct {
        logic [31:0]  hi;
        logic [31:0]  lo;
        int unsigned  cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, is_signed, mf_req, mf_sel_hi, flush;
    logic [31:0] op_a, op_b, mf_data, hi, lo;
    logic        stall, busy, done;

    logic        b_start, b_is_signed, b_mf_req, b_mf_sel_hi, b_flush;
    logic [31:0] b_op_a, b_op_b, b_mf_data, b_hi, b_lo;
    logic        b_stall, b_busy, b_done;

    int unsigned nchk = 0;
    int unsigned nfail = 0;
    int unsigned cyc = 0;
    exp_t        q[$];
    logic [63:0] model_hilo = '0;

    muldiv_seq_ctrl #(.STEP_BITS(1), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .mf_req(mf_req), .mf_sel_hi(mf_sel_hi),
        .flush(flush), .mf_data(mf_data), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    muldiv_seq_ctrl #(.STEP_BITS(2), .W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .is_signed(b_is_signed),
        .op_a(b_op_a), .op_b(b_op_b), .mf_req(b_mf_req), .mf_sel_hi(b_mf_sel_hi),
        .flush(b_flush), .mf_data(b_mf_data), .stall(b_stall), .busy(b_busy),
        .done(b_done), .hi(b_hi), .lo(b_lo)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        nchk++;
        nfail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: full 64-bit product of sign- or zero-extended operands
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Monitor: every done pulse must match the oldest expected result and its cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                timeout("done_unexpected");
            end else begin
                e = q.pop_front();
                chk("result", {hi, lo}, {e.hi, e.lo});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Present a multiply, hold it until accepted, optionally queue its result
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, output int unsigned stalls);
        logic [63:0] p;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        #1;
        stalls = 0;
        while (stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 200) timeout("issue_wait");
        if (push) begin
            p = ref_mul(a, b, s);
            model_hilo = p;
            q.push_back('{p[63:32], p[31:0], cyc + NIT + 2});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) timeout("drain");
        @(posedge clk);
    endtask

    initial begin
        int unsigned st, n;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 0; is_signed = 0; op_a = '0; op_b = '0;
        mf_req = 0; mf_sel_hi = 0; flush = 0;
        b_start = 0; b_is_signed = 0; b_op_a = '0; b_op_b = '0;
        b_mf_req = 0; b_mf_sel_hi = 0; b_flush = 0;

        // Reset state
        #12;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_flags", {61'h0, busy, done, stall}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_flags", {61'h0, busy, done, stall}, 64'h0);

        // Directed results
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, st); drain();
        chk("umax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1, st); drain();
        chk("neg3x5_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1, st); drain();
        chk("minxmin_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

        // Read hazard behind a multiply
        issue(32'd7, 32'd6, 1'b0, 1, st);
        mf_sel_hi = 1'b0; mf_req = 1'b1;
        #1;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("mflo_stall_cycles", 64'(n), 64'(NIT + 1));
        chk("mflo_data", 64'(mf_data), 64'h2A);
        mf_sel_hi = 1'b1; #1;
        chk("mfhi_no_stall", 64'(stall), 64'h0);
        chk("mfhi_data", 64'(mf_data), 64'h0);
        @(posedge clk); #1; mf_req = 1'b0;
        drain();

        // Simultaneous start and read in IDLE returns the old LO
        @(negedge clk);
        start = 1; op_a = 32'd3; op_b = 32'd3; is_signed = 0;
        mf_req = 1; mf_sel_hi = 0;
        #1;
        chk("simul_no_stall", 64'(stall), 64'h0);
        chk("simul_old_lo", 64'(mf_data), 64'h2A);
        model_hilo = 64'd9;
        q.push_back('{32'h0, 32'd9, cyc + NIT + 2});
        @(posedge clk); #1; start = 0; mf_req = 0;
        chk("simul_accepted", 64'(busy), 64'h1);
        drain();

        // Back-to-back issue: second start held off by stall
        issue(32'h0001_2345, 32'h0000_0100, 1'b0, 1, st);
        issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1, st);
        chk("b2b_stall_cycles", 64'(st), 64'(NIT + 1));
        drain();
        chk("b2b_overwrite", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        // Flush at CALC cycle 10
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, st);
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", 64'(busy), 64'h1);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'h0);
        chk("flush_hilo_kept", {hi, lo}, model_hilo);
        repeat (NIT + 4) @(posedge clk);
        #1;
        chk("flush_hilo_later", {hi, lo}, model_hilo);

        // Flush together with start in IDLE
        @(negedge clk);
        start = 1; flush = 1; op_a = 32'd5; op_b = 32'd5; is_signed = 0;
        @(posedge clk); #1; start = 0; flush = 0;
        chk("flush_start_ignored", 64'(busy), 64'h0);

        // Asynchronous reset mid-CALC
        issue(32'h0000_1111, 32'h0000_2222, 1'b0, 0, st);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hilo", {hi, lo}, 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        model_hilo = '0;
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic with random gaps
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 7 == 3) ra = 32'h8000_0000;
            if (i % 5 == 4) rb = 32'h0;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1, st);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();
        chk("random_last_hilo", {hi, lo}, model_hilo);

        // STEP_BITS=2 instance: 17-cycle latency
        @(negedge clk);
        b_start = 1; b_op_a = 32'h0001_0000; b_op_b = 32'h0001_0000; b_is_signed = 0;
        @(posedge clk); #1; b_start = 0;
        repeat (16) @(posedge clk);
        #1;
        chk("step2_before", {b_hi, b_lo, 31'h0, b_busy}, {64'h0, 32'h1});
        @(posedge clk); #1;
        chk("step2_hilo", {b_hi, b_lo}, 64'h0000_0001_0000_0000);
        chk("step2_done", 64'(b_done), 64'h1);

        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multi-cycle multiply sequencer with architectural HI/LO registers for the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU issue from EX and runs an iterative shift-add multiply over several cycles.
- Serves MFHI/MFLO reads and raises a pipeline stall whenever an issue or read conflicts with an operation in flight.
- Replaces the level-triggered, clockless multiply helper with a properly clocked, interlocked unit.

Parameters:
- STEP_BITS, default 1: multiplier bits retired per CALC cycle; legal values 1, 2, 4. Number of CALC cycles N_ITER = 32/STEP_BITS.
- W, default 32: operand width. Only 32 is supported; the parameter exists for package consistency.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX stage issues a multiply this cycle.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  in  32  rs operand; sampled with start.
- op_b  in  32  rt operand; sampled with start.
- mf_req  in  1  EX stage requests an MFHI or MFLO read.
- mf_sel_hi  in  1  1 = MFHI, 0 = MFLO.
- flush  in  1  pipeline flush; aborts the operation in flight.
- mf_data  out  32  selected HI or LO value; combinational from the registers.
- stall  out  1  hold IF/ID/EX this cycle.
- busy  out  1  high in CALC or FIXUP.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Behaviour:
- Reset (async assert, sync release): state=IDLE; hi=0, lo=0, busy=0, done=0, stall=0; internal accumulator, multiplicand, counter and sign flag all cleared.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - If start=1 and flush=0, latch |op_a| and |op_b| (absolute values when is_signed=1, raw otherwise).
  - Latch neg = is_signed & (op_a[31] ^ op_b[31]).
  - Clear the 64-bit accumulator, set cnt=N_ITER-1, go to CALC.
- CALC:
  - Each cycle, add the multiplicand times the low STEP_BITS of the multiplier into the accumulator (shifted).
  - Shift the multiplier right by STEP_BITS, then decrement cnt.
  - When cnt==0, go to FIXUP.
- FIXUP:
  - Write hi/lo from the 64-bit product, negated (two's complement over all 64 bits) when neg=1.
  - Go to IDLE; done=1 in the following cycle.
- Latency: start sampled at edge 0; hi/lo update at edge N_ITER+1. That is 33 cycles for STEP_BITS=1 and 17 for STEP_BITS=2.
- busy = (state != IDLE).
- stall = busy & (start | mf_req). Combinational. It deasserts in the cycle hi/lo hold the new value, so an MFHI/MFLO issued behind a multiply returns the new product.
- start while busy: not accepted; stall holds EX so start is re-presented and accepted in the IDLE cycle after FIXUP.
- mf_req while idle: no stall; mf_data = mf_sel_hi ? hi : lo in the same cycle.
- Simultaneous start and mf_req in IDLE: the start is accepted, and the read returns the old hi/lo (program order: the read precedes the issue).
- flush:
  - In CALC or FIXUP: go to IDLE next edge; hi/lo are NOT updated; done is not pulsed.
  - Concurrent with start in IDLE: the start is ignored.
- Reset mid-operation: immediate return to IDLE with hi/lo=0.
- Arithmetic:
  - The accumulator is 64 bits with no overflow possible.
  - Signed magnitude of 0x80000000 is 0x80000000, treated as unsigned, so -2^31 × -2^31 yields 0x40000000_00000000.

Decomposition:
- Shared package muldiv_pkg holds:
  - state enum (IDLE, CALC, FIXUP);
  - localparam N_ITER;
  - width constants used by the hazard unit.
- One natural sub-module: muldiv_step_adder. It is the combinational STEP_BITS-wide partial-product add/shift, instantiated once in CALC.
- Control FSM, HI/LO registers and stall logic stay in the top module.

Test Plan:
- Unsigned max: MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- Signed mixed: MULT 0xFFFFFFFD (-3) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed -2^31 × -2^31 -> hi=0x40000000, lo=0.
- Read hazard: issue MULTU 7×6, then mf_req with MFLO on the next cycle -> stall high for exactly the remaining busy cycles; the read returns 0x0000002A; no stall on the following MFHI, which returns 0.
- Back-to-back issue: start held during busy -> stall=1 until FIXUP completes; the second multiply starts in the following IDLE cycle and its result overwrites hi/lo.
- Flush and reset: flush at CALC cycle 10 -> busy=0 next cycle, hi/lo keep their prior values (e.g. 0x12345678/0x9ABCDEF0), no done pulse. rst_n low mid-CALC -> hi=lo=0 and busy=0 asynchronously.
- STEP_BITS=2 build: MULTU 0x0001_0000 × 0x0001_0000 -> hi=0x00000001, lo=0 after 17 cycles.
